fir_out_decimator: RTL and testbench

Post-processing stage that sits directly downstream of the FIR filter. It accepts the full-precision filter sum every valid cycle and decimates it by a runtime factor. It rescales, rounds and saturates each kept sample to output width, then buffers the results in a small FIFO behind a valid/ready interface. The filter cannot stall, so overflow drops samples and is flagged; it never back-pressures.

---
 rtl/fir_out_decimator.sv | 224 ++++++++++++++++++++++
 tb/tb_fir_out_decimator.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fir_out_decimator.sv
// ---------------------------------------------------------------------------
// fir_out_decimator
//
// Sits after the FIR filter. The filter's full-precision sum is decimated by
// a factor M that can change at run time. Each sample that is kept is scaled
// with an arithmetic right shift, then rounded or truncated and saturated to
// OUT_WIDTH, and finally queued in a small FIFO behind a valid/ready port.
// The filter upstream cannot stall, so this block never pushes back on it.
// When the FIFO is full, a new sample is dropped and ovf_flag is raised.
//
// Build option:
//   FIR_DEC_ROUND_EN  defined   -> round half up (adds 2^(SHIFT-1), then shifts)
//                     undefined -> truncate toward minus infinity (shift only)
//
// Ports:
//   clk         in   clock, rising edge
//   rst         in   asynchronous reset, active low
//   i_sig       in   signed filter sum, IN_WIDTH bits
//   i_valid     in   i_sig is valid this cycle
//   enable      in   when low, input samples are ignored
//   dec_factor  in   decimation factor M (8 bits); 0 behaves as 1
//   clr         in   synchronous clear of the sticky flags
//   o_sig       out  signed sample at the FIFO head (0 while the FIFO is empty)
//   o_valid     out  FIFO is not empty
//   o_ready     in   consumer takes the head when o_valid && o_ready
//   fifo_level  out  current FIFO occupancy
//   sat_flag    out  sticky: a kept sample saturated
//   ovf_flag    out  sticky: a sample was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module fir_out_decimator #(
    parameter int IN_WIDTH   = 32,
    parameter int OUT_WIDTH  = 16,
    parameter int SHIFT      = 15,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic signed [IN_WIDTH-1:0]    i_sig,
    input  logic                          i_valid,
    input  logic                          enable,
    input  logic [7:0]                    dec_factor,
    input  logic                          clr,
    output logic signed [OUT_WIDTH-1:0]   o_sig,
    output logic                          o_valid,
    input  logic                          o_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          sat_flag,
    output logic                          ovf_flag
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    // One guard bit, so that the rounding add can never wrap.
    localparam int EW = IN_WIDTH + 1;

    localparam logic signed [EW-1:0] SAT_MAX = EW'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
    localparam logic signed [EW-1:0] SAT_MIN = ~SAT_MAX;

    // ------------------------------------------------------------------
    // Decimation phase
    // ------------------------------------------------------------------
    logic [7:0] ph_q, ph_d;
    logic [7:0] m_q, m_d;
    logic [7:0] m_new;
    logic [7:0] m_eff;
    logic       acc;
    logic       keep;

    always_comb begin
        acc   = i_valid && enable;
        m_new = (dec_factor == 8'd0) ? 8'd1 : dec_factor;
        // A new decimation period starts at ph == 0. The factor latched there
        // also sets the wrap point of that period, so it is used right away.
        m_eff = (ph_q == 8'd0) ? m_new : m_q;
        keep  = acc && (ph_q == 8'd0);
        ph_d  = ph_q;
        m_d   = m_q;
        if (acc) begin
            if (ph_q == 8'd0) begin
                m_d = m_new;
            end
            ph_d = (ph_q == (m_eff - 8'd1)) ? 8'd0 : (ph_q + 8'd1);
        end
    end

    // ------------------------------------------------------------------
    // Stage S1: holds the kept sample
    // ------------------------------------------------------------------
    logic                       s1_valid_q, s1_valid_d;
    logic signed [IN_WIDTH-1:0] s1_data_q, s1_data_d;

    always_comb begin
        s1_valid_d = keep;
        s1_data_d  = keep ? i_sig : s1_data_q;
    end

    // ------------------------------------------------------------------
    // Scale, round and saturate the sample held in S1
    // ------------------------------------------------------------------
    logic signed [EW-1:0]        ext;
    logic signed [EW-1:0]        biased;
    logic signed [EW-1:0]        scaled;
    logic signed [OUT_WIDTH-1:0] sat_val;
    logic                        sat_hit;

    assign ext = {s1_data_q[IN_WIDTH-1], s1_data_q};

`ifdef FIR_DEC_ROUND_EN
    localparam logic signed [EW-1:0] RND = EW'(64'sd1 <<< (SHIFT - 1));
    assign biased = ext + RND;
`else
    assign biased = ext;
`endif

    assign scaled = biased >>> SHIFT;

    always_comb begin
        sat_hit = 1'b0;
        sat_val = scaled[OUT_WIDTH-1:0];
        if (scaled > SAT_MAX) begin
            sat_val = SAT_MAX[OUT_WIDTH-1:0];
            sat_hit = 1'b1;
        end else if (scaled < SAT_MIN) begin
            sat_val = SAT_MIN[OUT_WIDTH-1:0];
            sat_hit = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    logic signed [OUT_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]               wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]               rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]               level_q, level_d;
    logic                        full;
    logic                        pop;
    logic                        push;
    logic                        drop;

    always_comb begin
        full = (level_q == LW'(FIFO_DEPTH));
        pop  = (level_q != '0) && o_ready;
        // If a pop happens on the same edge, it frees the slot, so a full
        // FIFO can still take the write.
        push = s1_valid_q && (!full || pop);
        drop = s1_valid_q && full && !pop;

        wr_ptr_d = push ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;

        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // The storage array has no reset. After a reset, the level and the
    // pointers mark every entry as empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= sat_val;
        end
    end

    // ------------------------------------------------------------------
    // Sticky flags: if clr and a new event occur in the same cycle, the
    // event wins
    // ------------------------------------------------------------------
    logic sat_q, sat_d;
    logic ovf_q, ovf_d;

    always_comb begin
        sat_d = clr ? 1'b0 : sat_q;
        ovf_d = clr ? 1'b0 : ovf_q;
        if (s1_valid_q && sat_hit) begin
            sat_d = 1'b1;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ph_q       <= 8'd0;
            m_q        <= 8'd1;
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            sat_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            ph_q       <= ph_d;
            m_q        <= m_d;
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            sat_q      <= sat_d;
            ovf_q      <= ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_valid    = (level_q != '0);
    // Force o_sig to zero while the FIFO is empty, so it reads 0 after reset
    // even though the storage itself is never cleared.
    assign o_sig      = o_valid ? mem_q[rd_ptr_q] : '0;
    assign fifo_level = level_q;
    assign sat_flag   = sat_q;
    assign ovf_flag   = ovf_q;

endmodule

// File: tb/tb_fir_out_decimator.sv
module tb_fir_out_decimator;

    logic               clk;
    logic               rst;
    logic signed [31:0] i_sig;
    logic               i_valid;
    logic               enable;
    logic [7:0]         dec_factor;
    logic               clr;
    logic signed [15:0] o_sig;
    logic               o_valid;
    logic               o_ready;
    logic [2:0]         fifo_level;
    logic               sat_flag;
    logic               ovf_flag;

    fir_out_decimator #(
        .IN_WIDTH  (32),
        .OUT_WIDTH (16),
        .SHIFT     (15),
        .FIFO_DEPTH(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_sig     (i_sig),
        .i_valid   (i_valid),
        .enable    (enable),
        .dec_factor(dec_factor),
        .clr       (clr),
        .o_sig     (o_sig),
        .o_valid   (o_valid),
        .o_ready   (o_ready),
        .fifo_level(fifo_level),
        .sat_flag  (sat_flag),
        .ovf_flag  (ovf_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    logic [15:0] got[$];
    logic [15:0] exp_q[$];

    typedef struct {
        logic [31:0] sig;
        logic [15:0] exp_sig;
        logic        exp_sat;
        logic        clr_w;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs are driven at the falling edge. Before each rising edge, the
    // bench records any word the consumer pops on that edge.
    task automatic tick();
        if (o_valid && o_ready) got.push_back($unsigned(o_sig));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic compare_got(input string name);
        chk({name, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk($sformatf("%s_%0d", name, i), got[i], exp_q[i]);
    endtask

    task automatic send(input logic [31:0] s);
        i_valid = 1'b1;
        i_sig   = s;
        tick();
        i_valid = 1'b0;
    endtask

    initial begin
        //                sig           round    trunc    sat(r) sat(t) clr_w
        vecs[0]  = '{32'h0000_4000, `ifdef FIR_DEC_ROUND_EN 16'h0001 `else 16'h0000 `endif, 1'b0, 1'b0};
        vecs[1]  = '{32'hFFFF_C000, `ifdef FIR_DEC_ROUND_EN 16'h0000 `else 16'hFFFF `endif, 1'b0, 1'b0};
        vecs[2]  = '{32'h4000_0000, 16'h7FFF, 1'b1, 1'b0};
        vecs[3]  = '{32'hC000_0000, 16'h8000, 1'b0, 1'b0};
        vecs[4]  = '{32'h7FFF_FFFF, 16'h7FFF, 1'b1, 1'b1};
        vecs[5]  = '{32'h8000_0000, 16'h8000, 1'b1, 1'b0};
        vecs[6]  = '{32'h0001_8000, 16'h0003, 1'b0, 1'b0};
        vecs[7]  = '{32'h0000_C000, `ifdef FIR_DEC_ROUND_EN 16'h0002 `else 16'h0001 `endif, 1'b0, 1'b0};
        vecs[8]  = '{32'hFFFF_7FFF, `ifdef FIR_DEC_ROUND_EN 16'hFFFF `else 16'hFFFE `endif, 1'b0, 1'b0};
        vecs[9]  = '{32'h3FFF_C000, 16'h7FFF, `ifdef FIR_DEC_ROUND_EN 1'b1 `else 1'b0 `endif, 1'b0};
        vecs[10] = '{32'hBFFF_8000, 16'h8000, 1'b1, 1'b0};
        vecs[11] = '{32'hFFFF_FFFF, `ifdef FIR_DEC_ROUND_EN 16'h0000 `else 16'hFFFF `endif, 1'b0, 1'b0};

        rst        = 1'b0;
        i_sig      = '0;
        i_valid    = 1'b0;
        enable     = 1'b1;
        dec_factor = 8'd1;
        clr        = 1'b0;
        o_ready    = 1'b0;
        @(negedge clk);
        @(negedge clk);

        chk("rst_o_valid", o_valid, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_sat", sat_flag, 0);
        chk("rst_ovf", ovf_flag, 0);
        chk("rst_o_sig", $unsigned(o_sig), 0);
        rst = 1'b1;
        tick();

        // Single-sample scaling and saturation vectors, M=1
        o_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            dec_factor = 8'd1;
            send(vecs[i].sig);
            clr = vecs[i].clr_w;
            tick();
            clr = 1'b0;
            chk($sformatf("vec%0d_valid", i), o_valid, 1);
            chk($sformatf("vec%0d_sig", i), $unsigned(o_sig), vecs[i].exp_sig);
            chk($sformatf("vec%0d_sat", i), sat_flag, vecs[i].exp_sat);
            tick();
            clr = 1'b1;
            tick();
            clr = 1'b0;
            if (vecs[i].exp_sat) chk($sformatf("vec%0d_sat_clr", i), sat_flag, 0);
        end
        chk("vec_drained", fifo_level, 0);

        // Decimation by 3, and first-output latency
        got.delete();
        dec_factor = 8'd3;
        for (int k = 1; k <= 9; k++) begin
            send(32'(k) << 15);
            if (k == 1) chk("dec_first_early", o_valid, 0);
            if (k == 2) begin
                chk("dec_first_valid", o_valid, 1);
                chk("dec_first_sig", $unsigned(o_sig), 1);
            end
        end
        repeat (4) tick();
        exp_q = '{16'd1, 16'd4, 16'd7};
        compare_got("dec3");

        // enable low: samples are ignored and the phase holds
        got.delete();
        enable = 1'b0;
        send(32'd50 << 15);
        send(32'd51 << 15);
        enable = 1'b1;
        repeat (3) tick();
        chk("enable_low_count", got.size(), 0);

        // A change of M takes effect at the next period; M=0 keeps every sample
        got.delete();
        dec_factor = 8'd3;
        send(32'd10 << 15);
        dec_factor = 8'd2;
        send(32'd11 << 15);
        send(32'd12 << 15);
        send(32'd13 << 15);
        send(32'd14 << 15);
        send(32'd15 << 15);
        send(32'd16 << 15);
        dec_factor = 8'd0;
        send(32'd20 << 15);
        send(32'd21 << 15);
        send(32'd22 << 15);
        repeat (4) tick();
        exp_q = '{16'd10, 16'd13, 16'd15, 16'd20, 16'd21, 16'd22};
        compare_got("mchg");

        // Overflow, then a push into a full FIFO on the same edge as a pop
        got.delete();
        dec_factor = 8'd1;
        o_ready    = 1'b0;
        for (int k = 1; k <= 6; k++) send(32'(k) << 15);
        repeat (2) tick();
        chk("ovf_level", fifo_level, 4);
        chk("ovf_flag", ovf_flag, 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("ovf_clr", ovf_flag, 0);
        send(32'd7 << 15);
        o_ready = 1'b1;
        tick();
        o_ready = 1'b0;
        chk("full_pop_level", fifo_level, 4);
        chk("full_pop_ovf", ovf_flag, 0);
        o_ready = 1'b1;
        repeat (5) tick();
        exp_q = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd7};
        compare_got("ovf_data");
        chk("ovf_drained", o_valid, 0);

        // Reset mid-stream: level 3, S1 valid, phase not at 0
        got.delete();
        o_ready    = 1'b0;
        dec_factor = 8'd3;
        send(32'h4000_0000);
        for (int k = 2; k <= 10; k++) send(32'(k) << 15);
        chk("pre_rst_level", fifo_level, 3);
        chk("pre_rst_sat", sat_flag, 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", o_valid, 0);
        chk("mid_rst_level", fifo_level, 0);
        chk("mid_rst_sat", sat_flag, 0);
        chk("mid_rst_ovf", ovf_flag, 0);
        chk("mid_rst_sig", $unsigned(o_sig), 0);
        @(negedge clk);
        chk("mid_rst_level2", fifo_level, 0);
        rst = 1'b1;
        tick();
        chk("post_rst_level", fifo_level, 0);
        o_ready = 1'b1;
        send(32'd5 << 15);
        tick();
        chk("post_rst_valid", o_valid, 1);
        chk("post_rst_sig", $unsigned(o_sig), 5);
        tick();
        chk("post_rst_drained", o_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
